conv_k_mem_addr_gen: RTL
========================

# conv_k_mem_addr_gen

Parametrised read-address generator for convolution kernel weight memories. It drives NPORTS weight-ROM read ports in lockstep. Each port sweeps one kernel of KSIZE taps REPEAT times, then steps to the next of NGROUPS kernel groups. It sits between a layer controller (start/done handshake) and the weight ROMs, and provides a stall input so the MAC datapath can back-pressure.

## Interface
Parameters:
- ADDR_W, 8, weight-ROM address width
- KSIZE, 25, taps per kernel (words per sweep)
- REPEAT, 64, sweeps of the same kernel before advancing group
- NGROUPS, 3, kernel groups stepped through per run
- GROUP_STRIDE, 25, address step between groups
- NPORTS, 2, parallel read ports
- PORT_STRIDE, 75, address step between adjacent ports
- BASE, 0, address of tap 0 / group 0 / port 0

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a run (sampled in IDLE or DONE)
- stall  in  1  hold all counters; suppresses valid
- addr  out  NPORTS*ADDR_W  port p at bits [p*ADDR_W +: ADDR_W]
- valid  out  1  addr is a real read this cycle
- tap_last  out  1  valid and tap == KSIZE-1
- sweep_last  out  1  tap_last and rep == REPEAT-1
- busy  out  1  state == RUN
- done  out  1  state == DONE

## Operation
- Internal counters: tap (0..KSIZE-1), rep (0..REPEAT-1), grp (0..NGROUPS-1). All are registered, with widths of $clog2(max,2).
- The FSM has three states: IDLE, RUN and DONE.
  - IDLE: start=1 moves to RUN and clears tap/rep/grp to 0.
  - RUN: on each cycle with stall=0, valid=1 and the counters advance.
    - tap increments and wraps at KSIZE-1.
    - On a tap wrap, rep increments and wraps at REPEAT-1.
    - On a rep wrap, grp increments.
    - On the cycle where tap, rep and grp are all at their maximum, the next state is DONE and the counters clear to 0.
  - RUN with stall=1: all state holds, valid=0.
  - DONE: done=1 is held until start=1. That start re-enters RUN with the counters cleared, exactly as from IDLE.
- start is ignored while in RUN.
- Address, combinational from the counter registers: addr[p] = BASE + grp*GROUP_STRIDE + tap + p*PORT_STRIDE, truncated to ADDR_W bits.
  - Internal arithmetic uses ADDR_W+8 bits.
  - A simulation-only assertion fires if any untruncated address reaches ≥2^ADDR_W.
- Outside RUN, addr shows the counter value (0-based, i.e. BASE + p*PORT_STRIDE). valid, tap_last and sweep_last are 0.
- Each run contains exactly KSIZE*REPEAT*NGROUPS valid cycles (4800 with default parameters).
- Degenerate values:
  - KSIZE=1 makes tap_last=valid on every cycle.
  - REPEAT=1 or NGROUPS=1 means the corresponding counter stays 0.
  - All three must be ≥1.

## Timing
- Reset (asynchronous): state=IDLE, tap=rep=grp=0. Outputs: addr[p]=BASE+p*PORT_STRIDE, valid=0, tap_last=0, sweep_last=0, busy=0, done=0.
- Reset asserted mid-run aborts immediately to IDLE. No done pulse is produced.
- Latency:
  - start sampled at edge N gives busy=1 and the first valid from cycle N+1. That first valid carries addr0=BASE.
  - The last valid is cycle N+KSIZE*REPEAT*NGROUPS plus the number of stall cycles. done=1 follows on the next cycle.
- stall takes effect in the same cycle (combinational gating of valid). A stall on the final valid cycle delays DONE.
- start and stall together in IDLE/DONE: start wins, and the stall applies from the first RUN cycle.

## Test plan
- Defaults, start pulse, no stall:
  - Port 0 reads 0..24 for 64 sweeps, then 25..49 ×64, then 50..74 ×64.
  - Port 1 reads 75..149 in the same pattern.
  - Exactly 4800 valid cycles, 192 tap_last, 3 sweep_last, then done=1.
- Random stall (~30%) with defaults: the address sequence is identical to the stall-free run, valid is never high while stall=1, and the total cycle count is 4800 plus the number of stall cycles.
- Restart: after done, assert start. A full second run reproduces the same sequence. start pulses during RUN have no effect.
- KSIZE=3, REPEAT=2, NGROUPS=2, GROUP_STRIDE=4, NPORTS=3, PORT_STRIDE=10, BASE=5:
  - Port 0 reads 5,6,7,5,6,7,9,10,11,9,10,11.
  - Ports 1 and 2 read the same sequence offset by +10 and +20.
  - 12 valid cycles.
- Reset asserted asynchronously at valid cycle 1000: outputs return to reset values immediately, with no done. A later start restarts from addr0=BASE.
- KSIZE=1, REPEAT=1, NGROUPS=1: one valid cycle with tap_last=sweep_last=1, then done on the next cycle.

Source files
------------

// File: rtl/conv_k_mem_addr_gen.sv
// conv_k_mem_addr_gen: lockstep read-address generator for kernel weight ROMs.
// Sweeps KSIZE taps REPEAT times per group, NGROUPS groups per run, on NPORTS ports.
module conv_k_mem_addr_gen #(
    parameter int ADDR_W       = 8,
    parameter int KSIZE        = 25,
    parameter int REPEAT       = 64,
    parameter int NGROUPS      = 3,
    parameter int GROUP_STRIDE = 25,
    parameter int NPORTS       = 2,
    parameter int PORT_STRIDE  = 75,
    parameter int BASE         = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stall,
    output logic [NPORTS*ADDR_W-1:0] addr,
    output logic                     valid,
    output logic                     tap_last,
    output logic                     sweep_last,
    output logic                     busy,
    output logic                     done
);

    localparam int TAP_W = (KSIZE > 1) ? $clog2(KSIZE) : 1;
    localparam int REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam int GRP_W = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam int AW    = ADDR_W + 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [GRP_W-1:0]   grp_q, grp_d;

    logic tap_max;
    logic rep_max;
    logic grp_max;
    logic run;

    assign tap_max = (tap_q == TAP_W'(KSIZE - 1));
    assign rep_max = (rep_q == REP_W'(REPEAT - 1));
    assign grp_max = (grp_q == GRP_W'(NGROUPS - 1));
    assign run     = (state_q == RUN);

    // Stall gates valid combinationally so the MAC sees it the same cycle.
    assign valid      = run && !stall;
    assign tap_last   = valid && tap_max;
    assign sweep_last = tap_last && rep_max;
    assign busy       = run;
    assign done       = (state_q == DONE);

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tap_q   <= '0;
            rep_q   <= '0;
            grp_q   <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            rep_q   <= rep_d;
            grp_q   <= grp_d;
        end
    end

    // Next state: nested tap/rep/grp wrap, run ends after the last tap of the last group.
    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        rep_d   = rep_q;
        grp_d   = grp_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    tap_d   = '0;
                    rep_d   = '0;
                    grp_d   = '0;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (tap_max) begin
                        tap_d = '0;
                        if (rep_max) begin
                            rep_d = '0;
                            if (grp_max) begin
                                grp_d   = '0;
                                state_d = DONE;
                            end else begin
                                grp_d = grp_q + GRP_W'(1);
                            end
                        end else begin
                            rep_d = rep_q + REP_W'(1);
                        end
                    end else begin
                        tap_d = tap_q + TAP_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tap_d   = '0;
                rep_d   = '0;
                grp_d   = '0;
            end
        endcase
    end

    // Per-port address, computed wide so overflow past ADDR_W can be caught.
    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        logic [AW-1:0] full;

        assign full = AW'(BASE)
                    + AW'(grp_q) * AW'(GROUP_STRIDE)
                    + AW'(tap_q)
                    + AW'(p * PORT_STRIDE);

        assign addr[p*ADDR_W +: ADDR_W] = full[ADDR_W-1:0];

        // Flags a parameter set whose address range does not fit the ROM.
        always_ff @(posedge clk) begin
            if (!reset) begin
                assert (full < (AW'(1) << ADDR_W))
                else $error("conv_k_mem_addr_gen: port %0d address overflow", p);
            end
        end
    end

endmodule
